// File: rtl/reshape_pkg.sv
// Shared types and constants for the activation reshape stream.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reshape_pkg;

  // Occupancy of the single-word output buffer.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Direction of the bit permutation applied to an accepted word.
  localparam logic MODE_TO_PLANAR      = 1'b0;
  localparam logic MODE_TO_INTERLEAVED = 1'b1;

  // Width of the bit-plane counter; kept at least one bit wide so the
  // single-level configuration still has a legal register.
  function automatic int plane_cnt_w(input int levels);
    return (levels > 1) ? $clog2(levels) : 1;
  endfunction

endpackage

// File: rtl/reshape_perm.sv
// Combinational bit permutation between lane-interleaved and bit-planar layouts.
// Latency: 0 cycles (pure wiring plus a 2:1 mux on mode).
// Backpressure: none; it sits in front of the buffer register.
module reshape_perm
  import reshape_pkg::*;
#(
  parameter int BINARY_LEVELS = 2,
  parameter int SIMD_WIDTH    = 32
) (
  input  logic                                  mode,
  input  logic [SIMD_WIDTH*BINARY_LEVELS-1:0]   in_data,
  output logic [SIMD_WIDTH*BINARY_LEVELS-1:0]   out_data
);

  logic [SIMD_WIDTH*BINARY_LEVELS-1:0] to_planar;
  logic [SIMD_WIDTH*BINARY_LEVELS-1:0] to_interleaved;

  // Level i of lane j lives at BINARY_LEVELS*j+i when interleaved and at
  // SIMD_WIDTH*i+j when planar; the two maps are exact inverses.
  for (genvar i = 0; i < BINARY_LEVELS; i++) begin : g_level
    for (genvar j = 0; j < SIMD_WIDTH; j++) begin : g_lane
      assign to_planar[SIMD_WIDTH*i + j]         = in_data[BINARY_LEVELS*j + i];
      assign to_interleaved[BINARY_LEVELS*j + i] = in_data[SIMD_WIDTH*i + j];
    end
  end

  assign out_data = (mode == MODE_TO_INTERLEAVED) ? to_interleaved : to_planar;

endmodule

// File: rtl/reshape_stream.sv
// Reshapes activation words between interleaved and planar layouts, optionally one plane per beat.
// Latency: 1 cycle from input acceptance to first output beat; one word per cycle when SERIAL=0.
// Backpressure: single-entry buffer; in_ready only when empty or the final beat leaves this cycle.
module reshape_stream
  import reshape_pkg::*;
#(
  parameter int BINARY_LEVELS = 2,
  parameter int SIMD_WIDTH    = 32,
  parameter int SERIAL        = 0
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic                                                          mode,
  input  logic [SIMD_WIDTH*BINARY_LEVELS-1:0]                           in_data,
  input  logic                                                          in_valid,
  output logic                                                          in_ready,
  output logic [((SERIAL != 0) ? SIMD_WIDTH : SIMD_WIDTH*BINARY_LEVELS)-1:0] out_data,
  output logic                                                          out_valid,
  input  logic                                                          out_ready,
  output logic                                                          out_last
);

  localparam int WORD_W = SIMD_WIDTH * BINARY_LEVELS;
  localparam int PW     = plane_cnt_w(BINARY_LEVELS);
  localparam logic [PW-1:0] LAST_PLANE = PW'(BINARY_LEVELS - 1);

  state_t              state_q;
  state_t              state_d;
  logic [WORD_W-1:0]   perm_data;
  logic [WORD_W-1:0]   word_q;
  logic                mode_q;
  logic [PW-1:0]       plane_q;
  logic                in_fire;
  logic                out_fire;
  logic                final_beat;

  // Permute before the register so the output path is a plain flop (plus plane mux).
  reshape_perm #(
    .BINARY_LEVELS (BINARY_LEVELS),
    .SIMD_WIDTH    (SIMD_WIDTH)
  ) u_perm (
    .mode     (mode),
    .in_data  (in_data),
    .out_data (perm_data)
  );

  // Output valid comes only from the buffer state, never from in_valid.
  assign out_valid = (state_q == FULL);

  // Whole-word output and interleaved words finish in one beat; planar words
  // in serial mode finish on the last plane.
  assign final_beat = out_valid &&
                      ((SERIAL == 0) || (mode_q == MODE_TO_INTERLEAVED) || (plane_q == LAST_PLANE));
  assign out_last   = final_beat;

  // Accept when empty, or when the buffered word is leaving this cycle; never during reset.
  assign in_ready = !rst && ((state_q == EMPTY) || (out_ready && final_beat));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Buffer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: load on accept, drain after the final beat unless refilled the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_fire && final_beat && !in_fire) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Buffered word, its captured mode, and the plane counter for serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      mode_q  <= MODE_TO_PLANAR;
      plane_q <= '0;
    end else begin
      if (in_fire) begin
        word_q <= perm_data;
        mode_q <= mode;
      end
      if (out_fire) begin
        plane_q <= final_beat ? '0 : plane_q + PW'(1);
      end
    end
  end

  if (SERIAL != 0) begin : g_serial
    logic [SIMD_WIDTH-1:0] plane_sel;

    // Pick the current bit-plane out of the buffered planar word.
    always_comb begin
      plane_sel = word_q[SIMD_WIDTH-1:0];
      for (int k = 0; k < BINARY_LEVELS; k++) begin
        if (plane_q == PW'(k)) begin
          plane_sel = word_q[k*SIMD_WIDTH +: SIMD_WIDTH];
        end
      end
    end

    // Interleaved words are not serialised: only their low lane group is emitted.
    assign out_data = (mode_q == MODE_TO_INTERLEAVED) ? word_q[SIMD_WIDTH-1:0] : plane_sel;
  end else begin : g_word
    assign out_data = word_q;
  end

endmodule

// File: doc/reshape_stream.md
RESHAPE_STREAM -- requirements
Module: reshape_stream

Interface
REQ-001 SHALL have parameter BINARY_LEVELS, default 2, number of activation bit levels per SIMD lane (>=1).
REQ-002 SHALL have parameter SIMD_WIDTH, default 32, number of SIMD lanes (>=1).
REQ-003 SHALL have parameter SERIAL, default 0; 0 = whole-word output, 1 = one bit-plane per output beat.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 mode  input  1  0 = interleaved->planar, 1 = planar->interleaved; sampled with in_data on acceptance.
REQ-008 in_data  input  SIMD_WIDTH*BINARY_LEVELS  input word.
REQ-009 in_valid  input  1  input word present.
REQ-010 in_ready  output  1  block accepts word this cycle.
REQ-011 out_data  output  OUT_W  output; OUT_W = SIMD_WIDTH if SERIAL=1, else SIMD_WIDTH*BINARY_LEVELS.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 out_last  output  1  final beat of a word (always 1 with out_valid when SERIAL=0).

Function
REQ-015 Interleaved->planar SHALL map out bit (SIMD_WIDTH*i + j) = in bit (BINARY_LEVELS*j + i), i level, j lane.
REQ-016 Planar->interleaved SHALL be the exact inverse: out bit (BINARY_LEVELS*j + i) = in bit (SIMD_WIDTH*i + j).
REQ-017 Transfer SHALL occur on valid&&ready; out_valid SHALL never depend combinationally on in_valid.
REQ-018 Word accepted in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1 (latency 1).
REQ-019 Block SHALL hold one buffered word; states EMPTY and FULL.
REQ-020 EMPTY->FULL on input fire; FULL->EMPTY on final-beat output fire without simultaneous input fire; FULL stays FULL on simultaneous final-beat output fire and input fire (new word loaded).
REQ-021 in_ready SHALL = EMPTY || (out_ready && final beat); back-to-back words SHALL sustain one word per cycle with SERIAL=0.
REQ-022 While out_valid && !out_ready, out_data, out_last SHALL stay stable.
REQ-023 SERIAL=1: planar result SHALL be emitted as BINARY_LEVELS beats, beat k = level k bits, plane counter 0..BINARY_LEVELS-1, wrapping to 0 after the final beat.
REQ-024 SERIAL=1 with mode=1 captured: word SHALL emit as single beat of its lower SIMD_WIDTH interleaved bits with out_last=1 (serialisation applies to planar mode only).
REQ-025 out_last SHALL be 1 exactly on the beat where plane counter = BINARY_LEVELS-1 (SERIAL=1, mode=0).
REQ-026 mode changes while FULL SHALL not affect the buffered word.
REQ-027 BINARY_LEVELS=1 SHALL degrade to identity pass-through with latency 1.

Reset
REQ-028 On rst: state EMPTY, out_valid=0, out_last=0, out_data=0, plane counter=0, captured mode=0.
REQ-029 in_ready SHALL be 0 during the cycle rst is high; 1 the cycle after.
REQ-030 Reset mid-serialisation SHALL discard the word; no further beats emitted.

Structure
REQ-031 Shared package reshape_pkg SHALL hold state enum (EMPTY, FULL) and mode constants (MODE_TO_PLANAR=0, MODE_TO_INTERLEAVED=1).
REQ-032 Bit permutation SHALL be a combinational sub-module reshape_perm (parameters BINARY_LEVELS, SIMD_WIDTH, input mode), instantiated once before the buffer register.

Verification (BINARY_LEVELS=2, SIMD_WIDTH=4)
REQ-033 SERIAL=0, mode=0, in_data=8'hAA -> next cycle out_data=8'hF0, out_last=1; in_data=8'h55 -> 8'h0F.
REQ-034 SERIAL=0, mode=1, in_data=8'hF0 -> out_data=8'hAA; random 1000 words round-tripped through two instances (mode 0 then 1) -> output equals input.
REQ-035 SERIAL=0, out_ready=1, in_valid=1 for 8 cycles -> 8 words out in 8 consecutive cycles, in_ready constantly 1.
REQ-036 out_ready=0 for 3 cycles after word 8'hAA -> out_data held 8'hF0, in_ready=0, second word not lost once out_ready=1.
REQ-037 SERIAL=1, mode=0, in_data=8'hAA -> beat0 4'h0 out_last=0, beat1 4'hF out_last=1; in_ready=0 during beat0.
REQ-038 SERIAL=1, rst asserted after beat0 -> out_valid=0 next cycle, no beat1, counter=0.
